mnacidpro_sequencer: RTL
========================

MNACIDPRO_SEQUENCER -- requirements
Module: mnacidpro_sequencer

Interface
REQ-001 SHALL have parameter PHASE_CYCLES, default 4: clocks per pump phase, at least 1.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 8: valve settle clocks before pumping in each step, at least 1.
REQ-003 SHALL have parameters BEAD_STROKES, LYSIS_STROKES, WASH_STROKES, ELUTE_STROKES, default 4 each: pump strokes per step, range 0-255.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: request one purification run.
REQ-007 SHALL have port abort, input, 1: terminate the run.
REQ-008 SHALL have port valve_ctrl, output, 11: chip valve control lines, 1 = pressurized/closed.
- bit map: 0 lysis, 1 wash, 2 elute, 3 dead_end, 4 vertical, 5 horiz, 6 waste, 7 bead, 8 loop_exit, 9 bead_trap, 10 collect.
REQ-009 SHALL have port pump, output, 3: peristaltic pump valve lines, 1 = closed.
REQ-010 SHALL have port busy, output, 1: run in progress.
REQ-011 SHALL have port done, output, 1: one-cycle pulse at run completion.
REQ-012 SHALL have port step, output, 3: current state encoding.
- encoding: IDLE 0, BEAD 1, LYSIS 2, WASH 3, ELUTE 4, DONE 5.

Function
REQ-013 SHALL sequence states IDLE -> BEAD -> LYSIS -> WASH -> ELUTE -> DONE -> IDLE.
REQ-014 SHALL leave IDLE on the edge where start=1 and abort=0; the next cycle has busy=1 and step=1.
REQ-015 SHALL register all outputs.
REQ-016 SHALL drive these valve_ctrl masks for every cycle of each state:
- IDLE/DONE: 0x7FF.
- BEAD: 0x53F.
- LYSIS: 0x6BE.
- WASH: 0x5BD.
- ELUTE: 0x1FB.
REQ-017 SHALL split each working state into a SETTLE sub-phase and a PUMP sub-phase.
- SETTLE: exactly SETTLE_CYCLES cycles, pump=3'b111.
- PUMP: follows SETTLE.
REQ-018 SHALL in PUMP cycle pump through the 6-phase pattern 110, 100, 101, 001, 011, 010, holding each phase PHASE_CYCLES cycles.
- Each step starts at phase 0.
REQ-019 SHALL count one stroke per completed 6-phase cycle; after the programmed number of strokes it enters the next state's SETTLE on the following cycle.
REQ-020 SHALL, when a step's stroke count is 0, skip PUMP and advance directly after SETTLE.
REQ-021 SHALL make each working state last exactly SETTLE_CYCLES + strokes*6*PHASE_CYCLES cycles.
REQ-022 SHALL hold DONE for one cycle with done=1 and busy=1, then return to IDLE with busy=0.
REQ-023 SHALL ignore start while busy=1; start asserted in the DONE cycle is also ignored.
REQ-024 SHALL, on abort=1 in any non-IDLE state, go to IDLE the next cycle with done=0 and all counters cleared.
- IDLE outputs: valve_ctrl=0x7FF, pump=3'b111.
- abort has priority over every other transition, including the DONE transition.
REQ-025 SHALL let abort=1 with start=1 in IDLE remain in IDLE.
REQ-026 SHALL size phase, stroke and settle counters to their parameter maxima; counters never wrap within a step.

Reset
REQ-027 SHALL, on rst=1, asynchronously force state IDLE and clear all counters.
- Outputs: valve_ctrl=0x7FF, pump=3'b111, busy=0, done=0, step=0.
REQ-028 SHALL, after reset mid-run, require a new start pulse; no run state is retained.

Configuration
REQ-029 SHALL, with macro MNACIDPRO_PAUSE_EN defined, add input port pause (1 bit).
- While pause=1 in a non-IDLE state: settle/phase/stroke counters and the state freeze, and valve_ctrl and pump hold their current values.
- abort and rst still take effect during pause.
REQ-030 SHALL, without MNACIDPRO_PAUSE_EN, have no pause port and never stall.

Verification
REQ-031 SHALL cover a full run with PHASE_CYCLES=2, SETTLE_CYCLES=3, all strokes=1: start pulse -> busy for 4*(3+12)+1=61 cycles, done pulse on the 61st, valve masks 0x53F/0x6BE/0x5BD/0x1FB in order.
REQ-032 SHALL cover the pump pattern in BEAD with PHASE_CYCLES=1: pump reads 110,100,101,001,011,010 on consecutive cycles after 3 cycles of 111.
REQ-033 SHALL cover abort during WASH PUMP: next cycle step=0, valve_ctrl=0x7FF, pump=111, done never asserted.
REQ-034 SHALL cover WASH_STROKES=0: WASH lasts exactly SETTLE_CYCLES cycles, then ELUTE.
REQ-035 SHALL cover rst asserted mid-LYSIS, then start reissued: outputs reset immediately; a new run begins in BEAD with phase 0.
REQ-036 SHALL cover pause=1 for 5 cycles in ELUTE PUMP (MNACIDPRO_PAUSE_EN defined): pump value constant across the pause; total run length extended by exactly 5 cycles.

Source files
------------

// File: rtl/mnacidpro_sequencer.sv
// Bead-based nucleic-acid purification sequencer: walks BEAD/LYSIS/WASH/ELUTE with a valve settle then peristaltic pumping.
// Optional macro MNACIDPRO_PAUSE_EN adds a pause input that freezes a working step in place.
module mnacidpro_sequencer #(
    parameter int PHASE_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int BEAD_STROKES  = 4,
    parameter int LYSIS_STROKES = 4,
    parameter int WASH_STROKES  = 4,
    parameter int ELUTE_STROKES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
`ifdef MNACIDPRO_PAUSE_EN
    input  logic        pause,
`endif
    output logic [10:0] valve_ctrl,
    output logic [2:0]  pump,
    output logic        busy,
    output logic        done,
    output logic [2:0]  step
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int PW = $clog2(PHASE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] PHASE_LAST  = PW'(PHASE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BEAD  = 3'd1,
        LYSIS = 3'd2,
        WASH  = 3'd3,
        ELUTE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t        r_state;
    logic          r_pumping;
    logic [SW-1:0] r_settleCnt;
    logic [PW-1:0] r_phaseCnt;
    logic [2:0]    r_phaseIdx;
    logic [7:0]    r_strokeCnt;

    state_t        w_nextState;
    state_t        w_advance;
    logic          w_nextPumping;
    logic [SW-1:0] w_nextSettle;
    logic [PW-1:0] w_nextPhaseCnt;
    logic [2:0]    w_nextPhaseIdx;
    logic [7:0]    w_nextStroke;
    logic [8:0]    w_strokes;
    logic          w_pause;
    logic [10:0]   w_nextValve;
    logic [2:0]    w_nextPump;

`ifdef MNACIDPRO_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    function automatic logic [8:0] strokesOf(input state_t s);
        case (s)
            BEAD:    strokesOf = 9'(BEAD_STROKES);
            LYSIS:   strokesOf = 9'(LYSIS_STROKES);
            WASH:    strokesOf = 9'(WASH_STROKES);
            ELUTE:   strokesOf = 9'(ELUTE_STROKES);
            default: strokesOf = 9'd0;
        endcase
    endfunction

    function automatic logic [10:0] valveMask(input state_t s);
        case (s)
            BEAD:    valveMask = 11'h53F;
            LYSIS:   valveMask = 11'h6BE;
            WASH:    valveMask = 11'h5BD;
            ELUTE:   valveMask = 11'h1FB;
            default: valveMask = 11'h7FF;
        endcase
    endfunction

    function automatic logic [2:0] pumpPattern(input logic [2:0] idx);
        case (idx)
            3'd0:    pumpPattern = 3'b110;
            3'd1:    pumpPattern = 3'b100;
            3'd2:    pumpPattern = 3'b101;
            3'd3:    pumpPattern = 3'b001;
            3'd4:    pumpPattern = 3'b011;
            default: pumpPattern = 3'b010;
        endcase
    endfunction

    // DONE is deliberately not pausable so that done stays a single-cycle pulse.
    always_comb begin
        w_nextState    = r_state;
        w_nextPumping  = r_pumping;
        w_nextSettle   = r_settleCnt;
        w_nextPhaseCnt = r_phaseCnt;
        w_nextPhaseIdx = r_phaseIdx;
        w_nextStroke   = r_strokeCnt;
        w_strokes      = strokesOf(r_state);
        w_advance      = state_t'(r_state + 3'd1);

        if ((r_state == IDLE) || abort || (r_state == DONE)) begin
            w_nextState    = (r_state == IDLE && start && !abort) ? BEAD : IDLE;
            w_nextPumping  = 1'b0;
            w_nextSettle   = '0;
            w_nextPhaseCnt = '0;
            w_nextPhaseIdx = '0;
            w_nextStroke   = '0;
        end else if (w_pause) begin
            w_nextState = r_state;
        end else if (!r_pumping) begin
            if (r_settleCnt == SETTLE_LAST) begin
                w_nextSettle   = '0;
                w_nextPhaseCnt = '0;
                w_nextPhaseIdx = '0;
                w_nextStroke   = '0;
                if (w_strokes == 9'd0) begin
                    w_nextState = w_advance;
                end else begin
                    w_nextPumping = 1'b1;
                end
            end else begin
                w_nextSettle = r_settleCnt + 1'b1;
            end
        end else if (r_phaseCnt != PHASE_LAST) begin
            w_nextPhaseCnt = r_phaseCnt + 1'b1;
        end else begin
            w_nextPhaseCnt = '0;
            if (r_phaseIdx != 3'd5) begin
                w_nextPhaseIdx = r_phaseIdx + 3'd1;
            end else begin
                w_nextPhaseIdx = '0;
                if (({1'b0, r_strokeCnt} + 9'd1) == w_strokes) begin
                    w_nextState   = w_advance;
                    w_nextPumping = 1'b0;
                    w_nextStroke  = '0;
                end else begin
                    w_nextStroke = r_strokeCnt + 8'd1;
                end
            end
        end

        w_nextValve = valveMask(w_nextState);
        w_nextPump  = w_nextPumping ? pumpPattern(w_nextPhaseIdx) : 3'b111;
    end

    // Outputs are registered from the next-state decode so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pumping   <= 1'b0;
            r_settleCnt <= '0;
            r_phaseCnt  <= '0;
            r_phaseIdx  <= '0;
            r_strokeCnt <= '0;
            valve_ctrl  <= 11'h7FF;
            pump        <= 3'b111;
            busy        <= 1'b0;
            done        <= 1'b0;
            step        <= 3'd0;
        end else begin
            r_state     <= w_nextState;
            r_pumping   <= w_nextPumping;
            r_settleCnt <= w_nextSettle;
            r_phaseCnt  <= w_nextPhaseCnt;
            r_phaseIdx  <= w_nextPhaseIdx;
            r_strokeCnt <= w_nextStroke;
            valve_ctrl  <= w_nextValve;
            pump        <= w_nextPump;
            busy        <= (w_nextState != IDLE);
            done        <= (w_nextState == DONE);
            step        <= w_nextState;
        end
    end

endmodule
